// File: rtl/fetch_op_queue_pkg.sv
// Shared definitions for the fetch/op queue: op-code constants, tag sentinel
// and the packed entry layout held in the queue storage.
package fetch_op_queue_pkg;

    localparam int OP_W  = 5;
    localparam int TAG_W = 5;

    // Op-code encoding shared with the decoder and the issue stage.
    localparam logic [OP_W-1:0] OP_NONE  = 5'd0;
    localparam logic [OP_W-1:0] OP_LUI   = 5'd1;
    localparam logic [OP_W-1:0] OP_AUIPC = 5'd2;
    localparam logic [OP_W-1:0] OP_JAL   = 5'd3;
    localparam logic [OP_W-1:0] OP_JALR  = 5'd4;
    localparam logic [OP_W-1:0] OP_BEQ   = 5'd5;
    localparam logic [OP_W-1:0] OP_BNE   = 5'd6;
    localparam logic [OP_W-1:0] OP_BLT   = 5'd7;
    localparam logic [OP_W-1:0] OP_BGE   = 5'd8;
    localparam logic [OP_W-1:0] OP_BLTU  = 5'd9;
    localparam logic [OP_W-1:0] OP_BGEU  = 5'd10;
    localparam logic [OP_W-1:0] OP_LB    = 5'd11;
    localparam logic [OP_W-1:0] OP_LH    = 5'd12;
    localparam logic [OP_W-1:0] OP_LW    = 5'd13;
    localparam logic [OP_W-1:0] OP_LBU   = 5'd14;
    localparam logic [OP_W-1:0] OP_LHU   = 5'd15;
    localparam logic [OP_W-1:0] OP_SB    = 5'd16;
    localparam logic [OP_W-1:0] OP_SH    = 5'd17;
    localparam logic [OP_W-1:0] OP_SW    = 5'd18;
    localparam logic [OP_W-1:0] OP_ADDI  = 5'd19;

    // Rename-tag value meaning "no producer"; shared with the issue stage.
    localparam logic [TAG_W-1:0] TAG_NONE = '1;

    // One queued instruction: 32 + 32 + 4*5 + 4 = 88 bits.
    typedef struct packed {
        logic [31:0]     addr;
        logic [31:0]     imm;
        logic [OP_W-1:0] op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            branch;
        logic            ls;
        logic            use_imm;
        logic            jalr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_op_queue_ram.sv
// DEPTH x 88-bit entry storage: one synchronous write port, one
// asynchronous read port. Contents are cleared by reset.
module fetch_op_queue_ram
    import fetch_op_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  fq_entry_t        wdata,
    input  logic [PTR_W-1:0] raddr,
    output fq_entry_t        rdata
);

    fq_entry_t mem_q [DEPTH];
    fq_entry_t mem_d [DEPTH];

    // Next-state of the array: hold everything, overwrite the written slot.
    always_comb begin
        // NOTE: assigning the full default first keeps this block free of inferred latches.
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Array register, cleared asynchronously on reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            // NOTE: the storage is reset on purpose so stale entries never leak onto the head outputs.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_op_queue.sv
// Circular FIFO between the decoder and the issue stage. The head entry is
// shown to both the reservation station and the load/store buffer and is
// popped only when neither reports launch_fail. Flush empties the queue.
module fetch_op_queue
    import fetch_op_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             dec_valid,
    input  logic [4:0]       dec_op,
    input  logic             dec_branch,
    input  logic             dec_ls,
    input  logic             dec_use_imm,
    input  logic [4:0]       dec_rd,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic [31:0]      dec_imm,
    input  logic             dec_jalr,
    input  logic [31:0]      dec_addr,
    output logic             in_ready,
    output logic [4:0]       op,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic             branch_out,
    output logic             ls,
    output logic             use_imm,
    output logic             jalr,
    output logic [31:0]      imm,
    output logic [31:0]      addr,
    output logic             inst_valid,
    input  logic             rs_launch_fail,
    input  logic             lsb_launch_fail,
    output logic [PTR_W:0]   count_out
);

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic      full, empty, push, pop;
    fq_entry_t wr_entry, rd_entry, head_entry;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // Ready depends only on local state, never on the launch_fail inputs.
    assign in_ready = rdy_in & ~full;
    assign push     = dec_valid & in_ready & (dec_op != OP_NONE) & ~flush_in;
    assign pop      = ~empty & rdy_in & ~rs_launch_fail & ~lsb_launch_fail & ~flush_in;

    assign wr_entry = '{addr: dec_addr, imm: dec_imm, op: dec_op, rd: dec_rd,
                        rs1: dec_rs1, rs2: dec_rs2, branch: dec_branch, ls: dec_ls,
                        use_imm: dec_use_imm, jalr: dec_jalr};

    fetch_op_queue_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .we     (push),
        .waddr  (tail_q),
        .wdata  (wr_entry),
        .raddr  (head_q),
        .rdata  (rd_entry)
    );

    // Pointer and occupancy next-state; flush overrides any push or pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy_in) begin
            if (flush_in) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (push) tail_d = tail_q + PTR_ONE;
                if (pop)  head_d = head_q + PTR_ONE;
                case ({push, pop})
                    2'b10:   count_d = count_q + CNT_ONE;
                    2'b01:   count_d = count_q - CNT_ONE;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    // Control registers, cleared asynchronously on reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Head fields read as zero whenever the queue is empty.
    assign head_entry = empty ? '0 : rd_entry;
    assign inst_valid = ~empty;
    assign op         = head_entry.op;
    assign rd         = head_entry.rd;
    assign rs1        = head_entry.rs1;
    assign rs2        = head_entry.rs2;
    assign branch_out = head_entry.branch;
    assign ls         = head_entry.ls;
    assign use_imm    = head_entry.use_imm;
    assign jalr       = head_entry.jalr;
    assign imm        = head_entry.imm;
    assign addr       = head_entry.addr;
    assign count_out  = count_q;

    a_count_bound: assert property (@(posedge clk_in) disable iff (!rst_in) count_q <= DEPTH_C);
    a_no_empty_pop: assert property (@(posedge clk_in) disable iff (!rst_in) !(pop && empty));

endmodule
